// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the requesters and the round-robin stage, and its registered output stream.
// The slave modport is the arbiter's view. The master modport is the environment's view.
interface mux_rr_arbiter_if #(
  parameter int NUM_IN = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_IN)
);
  logic [NUM_IN-1:0] in_valid;
  logic [DATA_W-1:0] in_data [0:NUM_IN-1];
  logic [NUM_IN-1:0] in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  out_sel;
  logic [NUM_IN-1:0] out_sel_onehot;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_sel_onehot
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_sel_onehot
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin pick of one of NUM_IN requesters into a single registered beat carrying data plus binary/one-hot select.
// Latency: 1 cycle from accept to out_valid. Sustains one beat per cycle while out_ready is high.
// Backpressure: when the output is full and out_ready is low, all in_ready bits stay low and the rotation pointer holds.
module mux_rr_arbiter #(
  parameter int NUM_IN = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input logic              clk,
  input logic              rst,
  mux_rr_arbiter_if.slave  bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  grant_idx;
  logic [SEL_W-1:0]  scan_idx;
  logic              grant_found;
  logic              can_load;
  logic              accept;
  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  sel_q;
  logic [NUM_IN-1:0] onehot_q;

  // Scan from the farthest offset down to offset 0, so the port nearest rr_ptr wins.
  // NUM_IN is a power of two, so the SEL_W-bit sum wraps modulo NUM_IN.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr;
    scan_idx    = rr_ptr;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      scan_idx = rr_ptr + SEL_W'(k);
      if (bus.in_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign can_load     = (state == EMPTY) || bus.out_ready;
  assign accept       = grant_found && can_load && !rst;
  assign bus.in_ready = accept ? (NUM_IN'(1) << grant_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      rr_ptr   <= '0;
      data_q   <= '0;
      sel_q    <= '0;
      onehot_q <= '0;
    end else if (accept) begin
      state    <= FULL;
      data_q   <= bus.in_data[grant_idx];
      sel_q    <= grant_idx;
      onehot_q <= NUM_IN'(1) << grant_idx;
      rr_ptr   <= grant_idx + SEL_W'(1);
    end else if (state == FULL && bus.out_ready) begin
      // Drain with nothing to refill. Data and select keep their last values.
      state    <= EMPTY;
      onehot_q <= '0;
    end
  end

  assign bus.out_valid      = (state == FULL);
  assign bus.out_data       = data_q;
  assign bus.out_sel        = sel_q;
  assign bus.out_sel_onehot = onehot_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for the round-robin stage: randomized traffic against a queue-free reference model, plus directed literal scenarios.
module tb_mux_rr_arbiter;
  localparam int NUM = 8;
  localparam int DW  = 8;
  localparam int SW  = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: the registered beat and the next search start.
  bit       mvalid = 1'b0;
  logic [7:0] mdata = '0;
  int       msel   = 0;
  int       mptr   = 0;

  mux_rr_arbiter_if #(.NUM_IN(NUM), .DATA_W(DW), .SEL_W(SW)) bus ();

  mux_rr_arbiter #(.NUM_IN(NUM), .DATA_W(DW), .SEL_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int ptr, input logic [NUM-1:0] v);
    for (int k = 0; k < NUM; k++) begin
      int p;
      p = (ptr + k) % NUM;
      if (v[p] === 1'b1) return p;
    end
    return -1;
  endfunction

  // Model update at each active edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mvalid = 1'b0; mdata = '0; msel = 0; mptr = 0;
    end else begin
      int g;
      g = pick(mptr, bus.in_valid);
      if (g >= 0 && (!mvalid || bus.out_ready)) begin
        mvalid = 1'b1; mdata = bus.in_data[g]; msel = g; mptr = (g + 1) % NUM;
      end else if (mvalid && bus.out_ready) begin
        mvalid = 1'b0;
      end
    end
  end

  // Compare process on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data", 32'(bus.out_data), 0);
      chk("rst_out_sel", 32'(bus.out_sel), 0);
      chk("rst_out_onehot", 32'(bus.out_sel_onehot), 0);
    end else begin
      int g;
      logic [NUM-1:0] exp_rdy;
      g = pick(mptr, bus.in_valid);
      exp_rdy = (g >= 0 && (!mvalid || bus.out_ready)) ? (NUM'(1) << g) : '0;
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(bus.out_valid), 32'(mvalid));
      chk("out_data", 32'(bus.out_data), 32'(mdata));
      chk("out_sel", 32'(bus.out_sel), 32'(msel));
      chk("out_sel_onehot", 32'(bus.out_sel_onehot), mvalid ? (32'd1 << msel) : 32'd0);
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = '0;
    edge1();
    rst = 1'b0;
  endtask

  initial begin
    int exp_seq [10];
    rst = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_valid  = '0;
    for (int i = 0; i < NUM; i++) bus.in_data[i] = '0;

    // Reset held with random inputs.
    for (int c = 0; c < 3; c++) begin
      bus.in_valid  = NUM'($urandom);
      bus.out_ready = 1'($urandom);
      for (int i = 0; i < NUM; i++) bus.in_data[i] = DW'($urandom);
      @(negedge clk);
      chk("lit_rst_in_ready", 32'(bus.in_ready), 0);
      chk("lit_rst_out_valid", 32'(bus.out_valid), 0);
      edge1();
    end
    rst = 1'b0;
    bus.in_valid = 8'h01; bus.in_data[0] = 8'hA5; bus.out_ready = 1'b1;
    edge1();
    chk("lit_first_valid", 32'(bus.out_valid), 1);
    chk("lit_first_data", 32'(bus.out_data), 32'hA5);
    chk("lit_first_sel", 32'(bus.out_sel), 0);
    chk("lit_first_onehot", 32'(bus.out_sel_onehot), 32'h01);

    // Full rotation from port 0.
    do_reset();
    for (int i = 0; i < NUM; i++) bus.in_data[i] = 8'h10 + 8'(i);
    bus.in_valid = 8'hFF; bus.out_ready = 1'b1;
    exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    for (int c = 0; c < 10; c++) begin
      edge1();
      chk("lit_rot_sel", 32'(bus.out_sel), 32'(exp_seq[c]));
      chk("lit_rot_data", 32'(bus.out_data), 32'h10 + 32'(exp_seq[c]));
    end

    // Skip and wrap with the pointer at 6.
    do_reset();
    bus.in_valid = 8'h20;
    edge1();
    bus.in_valid = 8'b0000_0101;
    exp_seq = '{0, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("lit_wrap_ready", 32'(bus.in_ready), 32'd1 << exp_seq[c]);
      edge1();
      chk("lit_wrap_sel", 32'(bus.out_sel), 32'(exp_seq[c]));
    end

    // Backpressure while full on port 3.
    do_reset();
    bus.in_data[3] = 8'h3C; bus.in_valid = 8'h08; bus.out_ready = 1'b1;
    edge1();
    bus.in_valid = 8'hFF; bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("lit_stall_ready", 32'(bus.in_ready), 0);
      edge1();
      chk("lit_stall_valid", 32'(bus.out_valid), 1);
      chk("lit_stall_sel", 32'(bus.out_sel), 3);
      chk("lit_stall_data", 32'(bus.out_data), 32'h3C);
      chk("lit_stall_onehot", 32'(bus.out_sel_onehot), 32'h08);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("lit_unstall_ready", 32'(bus.in_ready), 32'h10);
    edge1();
    chk("lit_unstall_sel", 32'(bus.out_sel), 4);

    // Drain to empty.
    bus.in_valid = 8'h00;
    edge1();
    chk("lit_drain_valid", 32'(bus.out_valid), 0);
    chk("lit_drain_onehot", 32'(bus.out_sel_onehot), 0);
    chk("lit_drain_sel", 32'(bus.out_sel), 4);
    chk("lit_drain_data", 32'(bus.out_data), 32'h14);

    // Asynchronous reset between edges while full.
    bus.in_valid = 8'hFF; bus.out_ready = 1'b0;
    edge1();
    #2;
    rst = 1'b1;
    #1;
    chk("lit_async_valid", 32'(bus.out_valid), 0);
    chk("lit_async_onehot", 32'(bus.out_sel_onehot), 0);
    edge1();
    rst = 1'b0; bus.in_valid = 8'h80; bus.out_ready = 1'b1;
    edge1();
    chk("lit_post_rst_sel", 32'(bus.out_sel), 7);
    chk("lit_post_rst_data", 32'(bus.out_data), 32'h17);
    bus.in_valid = 8'hFF;
    edge1();
    chk("lit_post_rst_wrap", 32'(bus.out_sel), 0);

    // Randomized traffic checked by the compare process.
    for (int c = 0; c < 3000; c++) begin
      int mode;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      mode = $urandom_range(0, 3);
      case (mode)
        0: bus.in_valid = NUM'($urandom);
        1: bus.in_valid = NUM'(1) << $urandom_range(0, NUM - 1);
        2: bus.in_valid = '1;
        default: bus.in_valid = NUM'($urandom) & NUM'($urandom);
      endcase
      bus.out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NUM; i++) bus.in_data[i] = DW'($urandom);
      edge1();
    end
    rst = 1'b0;
    bus.in_valid = '0;
    edge1();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
